// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset. It re-sequences on lock loss, lock timeout or a relock request.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int SYS_RST_HOLD_CYCLES = 64,
    parameter int CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             pll_ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_HOLD,
        S_RUN
    } state_t;

    localparam int MAX_AB = (PLL_RST_CYCLES > SYS_RST_HOLD_CYCLES) ? PLL_RST_CYCLES : SYS_RST_HOLD_CYCLES;
    localparam int MAX_T  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int TMR_W  = $clog2(MAX_T + 1);
    localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(SYS_RST_HOLD_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [TMR_W-1:0]   r_timer;
    logic [STB_W-1:0]   r_stable;
    logic [CNT_W-1:0]   r_loss_cnt;
    logic [CNT_W-1:0]   r_to_cnt;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_pll_ready;

    state_t             w_state_nxt;
    logic [STB_W-1:0]   w_stable_nxt;
    logic               w_loss_evt;
    logic               w_to_evt;
    logic               w_entry;
    logic               w_lock_s;

    assign w_lock_s = r_sync2;
    assign w_entry  = (w_state_nxt != r_state);

    // Transition rules; lock loss outranks a relock request so it is always counted,
    // and a completed stability window outranks a simultaneous timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_stable_nxt = '0;
        w_loss_evt   = 1'b0;
        w_to_evt     = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_timer == RST_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                w_stable_nxt = w_lock_s ? (r_stable + STB_W'(1)) : '0;
                if (relock_req) begin
                    w_state_nxt = S_PLL_RST;
                end else if (w_lock_s && (r_stable == STB_LAST)) begin
                    w_state_nxt = S_HOLD;
                end else if (r_timer == TO_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_to_evt    = 1'b1;
                end
            end
            S_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_loss_evt  = 1'b1;
                end else if (relock_req) begin
                    w_state_nxt = S_PLL_RST;
                end else if (r_timer == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_loss_evt  = 1'b1;
                end else if (relock_req) begin
                    w_state_nxt = S_PLL_RST;
                end
            end
            default: w_state_nxt = S_PLL_RST;
        endcase
    end

    // Outputs are registered from the next state so they always match r_state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= S_PLL_RST;
            r_timer     <= '0;
            r_stable    <= '0;
            r_loss_cnt  <= '0;
            r_to_cnt    <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_pll_ready <= 1'b0;
        end else begin
            r_sync1     <= pll_locked;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_pll_rst   <= (w_state_nxt == S_PLL_RST);
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_pll_ready <= (w_state_nxt == S_RUN);
            if (w_entry) begin
                r_timer  <= '0;
                r_stable <= '0;
            end else begin
                r_timer  <= (r_state == S_RUN) ? r_timer : (r_timer + TMR_W'(1));
                r_stable <= w_stable_nxt;
            end
            if (w_loss_evt && (r_loss_cnt != CNT_MAX)) r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            if (w_to_evt && (r_to_cnt != CNT_MAX))     r_to_cnt   <= r_to_cnt + CNT_W'(1);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign pll_ready     = r_pll_ready;
    assign lock_loss_cnt = r_loss_cnt;
    assign timeout_cnt   = r_to_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/relock traffic,
// checked every cycle against a phase/age reference model.
module tb_pll_reset_sequencer;

    localparam int PR = 4;
    localparam int LS = 8;
    localparam int TO = 32;
    localparam int HC = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_RUN  = 3;

    logic          refclk     = 1'b0;
    logic          rst        = 1'b1;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          pll_ready;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (PR),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .SYS_RST_HOLD_CYCLES (HC),
        .CNT_W               (CW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .pll_ready     (pll_ready),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 refclk = ~refclk;

    int passCount  = 0;
    int checkCount = 0;
    int edgeNo     = 0;

    int mPhase, mAge, mStable, mLoss, mTo;
    bit mHist1, mHist2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic modelReset();
        mPhase  = PH_RST;
        mAge    = 0;
        mStable = 0;
        mLoss   = 0;
        mTo     = 0;
        mHist1  = 1'b0;
        mHist2  = 1'b0;
    endtask

    task automatic modelEnter(input int p);
        mPhase  = p;
        mAge    = 0;
        mStable = 0;
    endtask

    // One refclk edge of the reference model; the lock seen now is the input from two edges ago.
    task automatic modelEdge(input bit lockIn, input bit req);
        bit lockS;
        lockS  = mHist2;
        mHist2 = mHist1;
        mHist1 = lockIn;
        case (mPhase)
            PH_RST: begin
                mAge++;
                if (mAge == PR) modelEnter(PH_WAIT);
            end
            PH_WAIT: begin
                if (req) begin
                    modelEnter(PH_RST);
                end else begin
                    mStable = lockS ? mStable + 1 : 0;
                    mAge++;
                    if (mStable == LS) begin
                        modelEnter(PH_HOLD);
                    end else if (mAge == TO) begin
                        modelEnter(PH_RST);
                        if (mTo < CNT_MAX) mTo++;
                    end
                end
            end
            PH_HOLD: begin
                if (!lockS) begin
                    if (mLoss < CNT_MAX) mLoss++;
                    modelEnter(PH_RST);
                end else if (req) begin
                    modelEnter(PH_RST);
                end else begin
                    mAge++;
                    if (mAge == HC) modelEnter(PH_RUN);
                end
            end
            default: begin
                if (!lockS) begin
                    if (mLoss < CNT_MAX) mLoss++;
                    modelEnter(PH_RST);
                end else if (req) begin
                    modelEnter(PH_RST);
                end
            end
        endcase
    endtask

    task automatic checkAll();
        checkOutput($sformatf("pll_rst@%0d", edgeNo), pll_rst, (mPhase == PH_RST));
        checkOutput($sformatf("sys_rst@%0d", edgeNo), sys_rst, (mPhase != PH_RUN));
        checkOutput($sformatf("pll_ready@%0d", edgeNo), pll_ready, (mPhase == PH_RUN));
        checkOutput($sformatf("lock_loss_cnt@%0d", edgeNo), lock_loss_cnt, mLoss);
        checkOutput($sformatf("timeout_cnt@%0d", edgeNo), timeout_cnt, mTo);
    endtask

    // Drive inputs at the falling edge, advance one rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit lockVal, input bit reqVal);
        pll_locked = lockVal;
        relock_req = reqVal;
        @(posedge refclk);
        modelEdge(lockVal, reqVal);
        @(negedge refclk);
        relock_req = 1'b0;
        edgeNo++;
        checkAll();
    endtask

    initial begin
        int firstReady;
        int base;
        int pllRstAt3;
        int pllRstAt4;
        int toAt35;
        int toAt36;
        bit pllRstAfter2;
        bit curLock;
        bit req;

        modelReset();
        rst        = 1'b1;
        pll_locked = 1'b1;
        repeat (2) @(negedge refclk);
        checkOutput("reset_pll_rst", pll_rst, 1);
        checkOutput("reset_sys_rst", sys_rst, 1);
        checkOutput("reset_pll_ready", pll_ready, 0);
        checkOutput("reset_loss_cnt", lock_loss_cnt, 0);
        checkOutput("reset_to_cnt", timeout_cnt, 0);

        // Startup with lock held high: release at edge PR+LS+HC.
        rst        = 1'b0;
        edgeNo     = 0;
        firstReady = -1;
        pllRstAt3  = -1;
        pllRstAt4  = -1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (edgeNo == 3) pllRstAt3 = int'(pll_rst);
            if (edgeNo == 4) pllRstAt4 = int'(pll_rst);
            if (pll_ready && firstReady < 0) firstReady = edgeNo;
        end
        checkOutput("startup_pll_rst_edge3", pllRstAt3, 1);
        checkOutput("startup_pll_rst_edge4", pllRstAt4, 0);
        checkOutput("startup_ready_edge", firstReady, PR + LS + HC);

        // Lock loss in RUN: reaction on the 3rd edge, then relock 16 edges later.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        pllRstAfter2 = pll_rst;
        pll_locked = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("loss_pll_rst_edge2", pllRstAfter2, 0);
        checkOutput("loss_pll_rst_edge3", pll_rst, 1);
        checkOutput("loss_cnt_one", lock_loss_cnt, 1);
        base       = edgeNo;
        firstReady = -1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (pll_ready && firstReady < 0) firstReady = edgeNo - base;
        end
        checkOutput("relock_ready_delay", firstReady, PR + LS + HC);

        // Relock request in RUN, then a second request during PLL_RST that must be ignored.
        applyStimulus(1'b1, 1'b1);
        checkOutput("req_pll_rst", pll_rst, 1);
        checkOutput("req_loss_cnt", lock_loss_cnt, 1);
        base = edgeNo;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("req_in_rst_ignored", pll_rst, 0);

        // One-cycle lock glitch after 5 stable cycles in WAIT_LOCK restarts the stability window.
        base       = edgeNo;
        firstReady = -1;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus((i == 4) ? 1'b0 : 1'b1, 1'b0);
            if (pll_ready && firstReady < 0) firstReady = edgeNo - base;
        end
        checkOutput("glitch_ready_delay", firstReady, 6 + LS + HC);
        checkOutput("glitch_no_timeout", timeout_cnt, 0);

        // Asynchronous reset between edges while in RUN.
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_pll_rst", pll_rst, 1);
        checkOutput("midrst_sys_rst", sys_rst, 1);
        checkOutput("midrst_pll_ready", pll_ready, 0);
        checkOutput("midrst_loss_cnt", lock_loss_cnt, 0);
        checkOutput("midrst_to_cnt", timeout_cnt, 0);
        modelReset();
        pll_locked = 1'b0;
        @(negedge refclk);
        rst    = 1'b0;
        edgeNo = 0;

        // No lock: pll_rst pulse every PR+TO edges, timeout counter saturates.
        toAt35 = -1;
        toAt36 = -1;
        for (int i = 0; i < 17 * (PR + TO) + 8; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (edgeNo == PR + TO - 1) toAt35 = int'(timeout_cnt);
            if (edgeNo == PR + TO)     toAt36 = int'(timeout_cnt);
        end
        checkOutput("timeout_before_first", toAt35, 0);
        checkOutput("timeout_first", toAt36, 1);
        checkOutput("timeout_saturated", timeout_cnt, CNT_MAX);

        // Random lock bursts and occasional relock requests.
        curLock = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (curLock) begin
                if ($urandom_range(0, 99) < 3) curLock = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 25) curLock = 1'b1;
            end
            req = ($urandom_range(0, 99) < 2);
            applyStimulus(curLock, req);
        end

        $display("[TB] done after %0d checks", checkCount);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
